// File: rtl/dec_scan_ctrl_pkg.sv
// Shared definitions for the decoder line-scan sequencer: state encoding and line count.
package dec_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } scan_state_t;

    localparam int          LINES     = 16;
    localparam int          LW        = $clog2(LINES);
    localparam logic [3:0]  LAST_LINE = 4'd15;

endpackage

// File: rtl/dec4to16.sv
// 4-to-16 line decoder with enable; all outputs low while disabled.
module dec4to16 (
    input  logic [3:0]  i_w,
    input  logic        i_en,
    output logic [15:0] o_y
);

    assign o_y = i_en ? (16'd1 << i_w) : 16'd0;

endmodule

// File: rtl/scan_dwell_cnt.sv
// Loadable down counter that times both the blank gap and the drive dwell.
// It holds at zero instead of wrapping; o_zero marks the last cycle of a phase.
module scan_dwell_cnt #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/dec_scan_ctrl.sv
// Sequences decoder lines 0..15 with a blank gap before each line and a fixed dwell.
// Handshake: start is a level request taken only in IDLE; stop is honoured in any state.
module dec_scan_ctrl
    import dec_scan_ctrl_pkg::*;
#(
    parameter int DWELL = 4,
    parameter int BLANK = 1,
    parameter int CW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        mode,
    output logic [3:0]  W,
    output logic        En,
    output logic        busy,
    output logic        line_done,
    output logic        frame_done,
    output logic [1:0]  o_dbg_state
);

    localparam logic [CW-1:0] DWELL_LD  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD  = CW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic          HAS_BLANK = (BLANK > 0);
    localparam logic          ONE_DWELL = (DWELL == 1);
    localparam logic [CW-1:0] FIRST_LD  = HAS_BLANK ? BLANK_LD : DWELL_LD;

    scan_state_t   r_state;
    logic          r_mode;
    logic          r_stop_pend;

    logic          w_cnt_load;
    logic [CW-1:0] w_cnt_val;
    logic          w_cnt_en;
    logic [CW-1:0] w_cnt;
    logic          w_cnt_zero;
    logic          w_stop_any;
    logic          w_continue;
    logic [3:0]    w_w_next;

    assign w_stop_any = stop | r_stop_pend;
    assign w_continue = !w_stop_any && ((W != LAST_LINE) || r_mode);
    assign w_w_next   = W + 4'd1;

    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        w_cnt_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = FIRST_LD;
                end
            end
            S_BLANK: begin
                if (stop) begin
                    w_cnt_load = 1'b1;
                end else if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = DWELL_LD;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            S_DRIVE: begin
                if (w_cnt_zero) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = w_continue ? FIRST_LD : '0;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            default: begin
                w_cnt_load = 1'b1;
            end
        endcase
    end

    scan_dwell_cnt #(.CW(CW)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_en       (w_cnt_en),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // Pulses are registered one edge early so they coincide with the final En=1 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_stop_pend <= 1'b0;
            W           <= '0;
            En          <= 1'b0;
            busy        <= 1'b0;
            line_done   <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            line_done  <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    W           <= '0;
                    En          <= 1'b0;
                    busy        <= 1'b0;
                    r_stop_pend <= 1'b0;
                    if (start && !stop) begin
                        r_mode <= mode;
                        busy   <= 1'b1;
                        if (HAS_BLANK) begin
                            r_state <= S_BLANK;
                        end else begin
                            r_state   <= S_DRIVE;
                            En        <= 1'b1;
                            line_done <= ONE_DWELL;
                        end
                    end
                end
                S_BLANK: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                        W       <= '0;
                        En      <= 1'b0;
                        busy    <= 1'b0;
                    end else if (w_cnt_zero) begin
                        r_state    <= S_DRIVE;
                        En         <= 1'b1;
                        line_done  <= ONE_DWELL;
                        frame_done <= ONE_DWELL && (W == LAST_LINE);
                    end
                end
                S_DRIVE: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (!w_cnt_zero) begin
                        line_done  <= (w_cnt == CW'(1));
                        frame_done <= (w_cnt == CW'(1)) && (W == LAST_LINE);
                    end else if (w_continue) begin
                        W <= w_w_next;
                        if (HAS_BLANK) begin
                            r_state <= S_BLANK;
                            En      <= 1'b0;
                        end else begin
                            En         <= 1'b1;
                            line_done  <= ONE_DWELL;
                            frame_done <= ONE_DWELL && (w_w_next == LAST_LINE);
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        W           <= '0;
                        En          <= 1'b0;
                        busy        <= 1'b0;
                        r_stop_pend <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    W       <= '0;
                    En      <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Directed bench for the line-scan sequencer driving a 4-to-16 decoder.
module tb_dec_scan_ctrl;

    logic clk;
    logic rst;
    logic start_a, stop_a, mode_a;
    logic start_b, stop_b, mode_b;

    logic [3:0]  w_a, w_b;
    logic        en_a, en_b, busy_a, busy_b;
    logic        ld_a, ld_b, fd_a, fd_b;
    logic [1:0]  dbg_a, dbg_b;
    logic [15:0] y_a, y_b;

    int checks   = 0;
    int failures = 0;
    int ld_cnt;
    int fd_cnt;
    logic [3:0] prev_w;

    dec_scan_ctrl u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stop(stop_a), .mode(mode_a),
        .W(w_a), .En(en_a), .busy(busy_a), .line_done(ld_a), .frame_done(fd_a),
        .o_dbg_state(dbg_a)
    );
    dec4to16 u_dec_a (.i_w(w_a), .i_en(en_a), .o_y(y_a));

    dec_scan_ctrl #(.DWELL(1), .BLANK(0), .CW(8)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .mode(mode_b),
        .W(w_b), .En(en_b), .busy(busy_b), .line_done(ld_b), .frame_done(fd_b),
        .o_dbg_state(dbg_b)
    );
    dec4to16 u_dec_b (.i_w(w_b), .i_en(en_b), .o_y(y_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {W, En, busy, line_done, frame_done} for the c-th cycle after start acceptance.
    function automatic logic [7:0] exp_vec(input int c, input int blank, input int dwell);
        int per, line, p;
        logic en, ld, fd;
        per  = blank + dwell;
        line = ((c - 1) / per) % 16;
        p    = (c - 1) % per;
        en   = (p >= blank);
        ld   = (p == per - 1);
        fd   = ld && (line == 15);
        return {4'(line), en, 1'b1, ld, fd};
    endfunction

    function automatic logic [15:0] exp_y(input int c, input int blank, input int dwell);
        int per, line, p;
        logic [15:0] one;
        per  = blank + dwell;
        line = ((c - 1) / per) % 16;
        p    = (c - 1) % per;
        one  = 16'd1;
        return (p >= blank) ? (one << line) : 16'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_scan_a(input string tag, input int c);
        chk($sformatf("%s_c%0d_vec", tag, c), 32'({w_a, en_a, busy_a, ld_a, fd_a}), 32'(exp_vec(c, 1, 4)));
        chk($sformatf("%s_c%0d_y", tag, c), 32'(y_a), 32'(exp_y(c, 1, 4)));
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_vec"}, 32'({w_a, en_a, busy_a, ld_a, fd_a}), 32'd0);
        chk({tag, "_y"}, 32'(y_a), 32'd0);
        chk({tag, "_state"}, 32'(dbg_a), 32'd0);
    endtask

    // Entered at the negedge of cycle 'first'; leaves at the negedge of cycle last+1.
    task automatic run_scan_a(input string tag, input int first, input int last);
        ld_cnt = 0;
        fd_cnt = 0;
        prev_w = w_a;
        for (int c = first; c <= last; c++) begin
            chk_scan_a(tag, c);
            if (c > first && w_a != prev_w) begin
                chk($sformatf("%s_c%0d_wchg_en", tag, c), 32'(en_a), 32'd0);
            end
            prev_w = w_a;
            ld_cnt += int'(ld_a);
            fd_cnt += int'(fd_a);
            @(negedge clk);
        end
    endtask

    task automatic accept_a(input logic m);
        mode_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        mode_a  = ~m;
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; stop_a = 1'b0; mode_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; mode_b = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_a("reset");
        chk("reset_b_vec", 32'({w_b, en_b, busy_b, ld_b, fd_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_idle_a("post_reset");

        // Single frame with defaults.
        accept_a(1'b0);
        run_scan_a("single", 1, 80);
        chk("single_line_done_count", 32'(ld_cnt), 32'd16);
        chk("single_frame_done_count", 32'(fd_cnt), 32'd1);
        chk_idle_a("single_end");

        // Continuous: two back-to-back frames, then stop in a blank.
        accept_a(1'b1);
        run_scan_a("cont", 1, 160);
        chk("cont_line_done_count", 32'(ld_cnt), 32'd32);
        chk("cont_frame_done_count", 32'(fd_cnt), 32'd2);
        chk_scan_a("cont_wrap", 161);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        chk_idle_a("cont_stop");

        // Stop on the second dwell cycle of line 5: line still completes.
        accept_a(1'b0);
        run_scan_a("sdrv", 1, 27);
        chk_scan_a("sdrv", 28);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        chk_scan_a("sdrv", 29);
        @(negedge clk);
        chk_scan_a("sdrv", 30);
        @(negedge clk);
        chk_idle_a("sdrv_end");

        // Restart from line 0, then stop in the blank before line 9.
        accept_a(1'b0);
        run_scan_a("sblk", 1, 45);
        chk_scan_a("sblk", 46);
        stop_a = 1'b1;
        @(negedge clk);
        stop_a = 1'b0;
        chk_idle_a("sblk_end");

        // Start and stop together: stop wins.
        start_a = 1'b1;
        stop_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        stop_a  = 1'b0;
        chk_idle_a("both_1");
        @(negedge clk);
        chk_idle_a("both_2");

        // Asynchronous reset in the drive phase of line 7.
        accept_a(1'b0);
        run_scan_a("arst", 1, 36);
        chk_scan_a("arst", 37);
        #2 rst = 1'b1;
        #1;
        chk_idle_a("arst_async");
        @(negedge clk);
        chk_idle_a("arst_held");
        rst = 1'b0;
        @(negedge clk);
        chk_idle_a("arst_release");
        accept_a(1'b0);
        run_scan_a("arst_full", 1, 80);
        chk("arst_full_line_done_count", 32'(ld_cnt), 32'd16);
        chk("arst_full_frame_done_count", 32'(fd_cnt), 32'd1);
        chk_idle_a("arst_full_end");

        // No blank, one-cycle dwell.
        mode_b  = 1'b0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        ld_cnt = 0;
        fd_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("var_c%0d_vec", c), 32'({w_b, en_b, busy_b, ld_b, fd_b}), 32'(exp_vec(c, 0, 1)));
            chk($sformatf("var_c%0d_y", c), 32'(y_b), 32'(exp_y(c, 0, 1)));
            ld_cnt += int'(ld_b);
            fd_cnt += int'(fd_b);
            @(negedge clk);
        end
        chk("var_line_done_count", 32'(ld_cnt), 32'd16);
        chk("var_frame_done_count", 32'(fd_cnt), 32'd1);
        chk("var_end_vec", 32'({w_b, en_b, busy_b, ld_b, fd_b}), 32'd0);
        chk("var_end_state", 32'(dbg_b), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
